// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode-side operands/control, MEM/WB forwarding sources,
// and the E-stage outputs that feed the ALU and the EX/MEM register.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
);
  // pipeline control
  logic               stall_e;
  logic               flush_e;
  // decode slot
  logic               valid_d;
  logic [WIDTH-1:0]   rd1_d, rd2_d, signimm_d;
  logic [REGADDR-1:0] rs_d, rt_d, rd_d;
  logic               regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
  logic [2:0]         alucontrol_d;
  // forwarding sources
  logic               regwrite_m;
  logic [REGADDR-1:0] writereg_m;
  logic [WIDTH-1:0]   aluout_m;
  logic               regwrite_w;
  logic [REGADDR-1:0] writereg_w;
  logic [WIDTH-1:0]   result_w;
  // E-stage outputs
  logic               lwstall;
  logic [WIDTH-1:0]   srca_e, srcb_e, writedata_e;
  logic [2:0]         alucontrol_e;
  logic [REGADDR-1:0] writereg_e;
  logic               valid_e, regwrite_e, memtoreg_e, memwrite_e;
  logic [31:0]        bubble_cnt, stall_cnt;

  modport master (
    output stall_e, flush_e, valid_d, rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d,
           regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, alucontrol_d,
           regwrite_m, writereg_m, aluout_m, regwrite_w, writereg_w, result_w,
    input  lwstall, srca_e, srcb_e, writedata_e, alucontrol_e, writereg_e,
           valid_e, regwrite_e, memtoreg_e, memwrite_e, bubble_cnt, stall_cnt
  );

  modport slave (
    input  stall_e, flush_e, valid_d, rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d,
           regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, alucontrol_d,
           regwrite_m, writereg_m, aluout_m, regwrite_w, writereg_w, result_w,
    output lwstall, srca_e, srcb_e, writedata_e, alucontrol_e, writereg_e,
           valid_e, regwrite_e, memtoreg_e, memwrite_e, bubble_cnt, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register for the 5-stage MIPS core.
// Priority per edge: reset > flush (bubble) > stall (hold) > load-use (bubble) > load.
// EX operands are forwarded from MEM (preferred) then WB; register 0 never forwards.
// Optional: define ID_EX_STATS_EN to build the bubble/stall performance counters;
// otherwise bubble_cnt/stall_cnt are constant 0 and no counter flops exist.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regdst;
    logic [2:0]         alucontrol;
    logic [REGADDR-1:0] rs;
    logic [REGADDR-1:0] rt;
    logic [REGADDR-1:0] rd;
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic [WIDTH-1:0]   signimm;
  } ex_t;

  ex_t  ex_q, ex_d;
  logic lwstall_c;

  // MEM result wins over WB; a zero specifier is never a forwarding target
  function automatic logic [WIDTH-1:0] fwd(
    input logic [REGADDR-1:0] src,
    input logic [WIDTH-1:0]   regval,
    input logic               rw_m,
    input logic [REGADDR-1:0] wr_m,
    input logic [WIDTH-1:0]   val_m,
    input logic               rw_w,
    input logic [REGADDR-1:0] wr_w,
    input logic [WIDTH-1:0]   val_w
  );
    logic [WIDTH-1:0] r;
    r = regval;
    if (src != '0 && src == wr_m && rw_m)      r = val_m;
    else if (src != '0 && src == wr_w && rw_w) r = val_w;
    return r;
  endfunction

  // load-use hazard: the load in E writes a register the decode slot reads
  always_comb begin
    lwstall_c = ex_q.valid & ex_q.memtoreg & (ex_q.rt != '0) &
                ((bus.rs_d == ex_q.rt) | (bus.rt_d == ex_q.rt)) &
                bus.valid_d & ~bus.flush_e;
  end

  // next E-stage state; bubbles clear only side-effecting control, datapath holds
  always_comb begin
    ex_d = ex_q;
    if (bus.flush_e || (!bus.stall_e && lwstall_c)) begin
      ex_d.valid    = 1'b0;
      ex_d.regwrite = 1'b0;
      ex_d.memtoreg = 1'b0;
      ex_d.memwrite = 1'b0;
    end else if (!bus.stall_e) begin
      ex_d.valid      = bus.valid_d;
      ex_d.regwrite   = bus.regwrite_d;
      ex_d.memtoreg   = bus.memtoreg_d;
      ex_d.memwrite   = bus.memwrite_d;
      ex_d.alusrc     = bus.alusrc_d;
      ex_d.regdst     = bus.regdst_d;
      ex_d.alucontrol = bus.alucontrol_d;
      ex_d.rs         = bus.rs_d;
      ex_d.rt         = bus.rt_d;
      ex_d.rd         = bus.rd_d;
      ex_d.rd1        = bus.rd1_d;
      ex_d.rd2        = bus.rd2_d;
      ex_d.signimm    = bus.signimm_d;
    end
  end

  // E-stage register with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) ex_q <= '0;
    else          ex_q <= ex_d;
  end

  // operand forwarding and output muxing
  always_comb begin
    bus.srca_e      = fwd(ex_q.rs, ex_q.rd1, bus.regwrite_m, bus.writereg_m, bus.aluout_m,
                          bus.regwrite_w, bus.writereg_w, bus.result_w);
    bus.writedata_e = fwd(ex_q.rt, ex_q.rd2, bus.regwrite_m, bus.writereg_m, bus.aluout_m,
                          bus.regwrite_w, bus.writereg_w, bus.result_w);
    bus.srcb_e      = ex_q.alusrc ? ex_q.signimm : bus.writedata_e;
    bus.writereg_e  = ex_q.regdst ? ex_q.rd : ex_q.rt;
  end

  assign bus.lwstall      = lwstall_c;
  assign bus.alucontrol_e = ex_q.alucontrol;
  assign bus.valid_e      = ex_q.valid;
  assign bus.regwrite_e   = ex_q.regwrite;
  assign bus.memtoreg_e   = ex_q.memtoreg;
  assign bus.memwrite_e   = ex_q.memwrite;

`ifdef ID_EX_STATS_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // count inserted bubbles and held cycles; wrap naturally at 2^32
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bus.flush_e || (!bus.stall_e && lwstall_c)) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (bus.stall_e && !bus.flush_e)                 stall_cnt_d  = stall_cnt_q + 32'd1;
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;
`else
  assign bus.bubble_cnt = '0;
  assign bus.stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver applies one directed vector per
// cycle (just after the rising edge) and queues the outputs expected in that
// cycle; the monitor pops and compares on every falling edge.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.WIDTH(32), .REGADDR(5)) bus ();
  id_ex_stage #(.WIDTH(32), .REGADDR(5)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic        rst_n, stall, flush, valid_d;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [2:0]  aluc;
    logic        rw_m;
    logic [4:0]  wr_m;
    logic [31:0] alu_m;
    logic        rw_w;
    logic [4:0]  wr_w;
    logic [31:0] res_w;
  } vin_t;

  localparam logic [7:0] M_A = 8'h01, M_B = 8'h02, M_WD = 8'h04, M_WR = 8'h08,
                         M_AC = 8'h10, M_CT = 8'h20, M_LW = 8'h40, M_CN = 8'h80;

  typedef struct packed {
    int          step;
    logic [7:0]  mask;
    logic [31:0] srca, srcb, wdata;
    logic [4:0]  wreg;
    logic [2:0]  aluc;
    logic [3:0]  ctrl;  // valid, regwrite, memtoreg, memwrite
    logic        lw;
    logic [31:0] bub, stl;
  } exp_t;

  exp_t q[$];
  vin_t v;
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   stepn = 0;

  task automatic apply();
    reset_n          = v.rst_n;
    bus.stall_e      = v.stall;
    bus.flush_e      = v.flush;
    bus.valid_d      = v.valid_d;
    bus.rd1_d        = v.rd1;
    bus.rd2_d        = v.rd2;
    bus.signimm_d    = v.imm;
    bus.rs_d         = v.rs;
    bus.rt_d         = v.rt;
    bus.rd_d         = v.rd;
    bus.regwrite_d   = v.regwrite;
    bus.memtoreg_d   = v.memtoreg;
    bus.memwrite_d   = v.memwrite;
    bus.alusrc_d     = v.alusrc;
    bus.regdst_d     = v.regdst;
    bus.alucontrol_d = v.aluc;
    bus.regwrite_m   = v.rw_m;
    bus.writereg_m   = v.wr_m;
    bus.aluout_m     = v.alu_m;
    bus.regwrite_w   = v.rw_w;
    bus.writereg_w   = v.wr_w;
    bus.result_w     = v.res_w;
  endtask

  // one cycle: drive vector after the edge, queue what must be seen this cycle
  task automatic step();
    @(posedge clk);
    #1;
    stepn++;
    e.step = stepn;
    apply();
    q.push_back(e);
    e = '0;
  endtask

  task automatic clr_d();
    v.valid_d = 0; v.rd1 = 0; v.rd2 = 0; v.imm = 0; v.rs = 0; v.rt = 0; v.rd = 0;
    v.regwrite = 0; v.memtoreg = 0; v.memwrite = 0; v.alusrc = 0; v.regdst = 0; v.aluc = 0;
  endtask

  task automatic cmp(input string n, input int s, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%08h expected=0x%08h", n, s, a, x);
    end
  endtask

  // monitor: compare queued expectations against the DUT mid-cycle
  initial begin
    exp_t x;
    logic [31:0] xb, xs;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
`ifdef ID_EX_STATS_EN
        xb = x.bub; xs = x.stl;
`else
        xb = 0; xs = 0;
`endif
        if ((x.mask & M_A)  != 0) cmp("srca_e", x.step, bus.srca_e, x.srca);
        if ((x.mask & M_B)  != 0) cmp("srcb_e", x.step, bus.srcb_e, x.srcb);
        if ((x.mask & M_WD) != 0) cmp("writedata_e", x.step, bus.writedata_e, x.wdata);
        if ((x.mask & M_WR) != 0) cmp("writereg_e", x.step, 32'(bus.writereg_e), 32'(x.wreg));
        if ((x.mask & M_AC) != 0) cmp("alucontrol_e", x.step, 32'(bus.alucontrol_e), 32'(x.aluc));
        if ((x.mask & M_CT) != 0)
          cmp("ctrl_e", x.step,
              32'({bus.valid_e, bus.regwrite_e, bus.memtoreg_e, bus.memwrite_e}), 32'(x.ctrl));
        if ((x.mask & M_LW) != 0) cmp("lwstall", x.step, 32'(bus.lwstall), 32'(x.lw));
        if ((x.mask & M_CN) != 0) begin
          cmp("bubble_cnt", x.step, bus.bubble_cnt, xb);
          cmp("stall_cnt", x.step, bus.stall_cnt, xs);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    e = '0;
    // 1: reset with every input driven high
    v = '1; v.rst_n = 0; v.stall = 0; v.flush = 0;
    step();
    // 2: reset has taken effect -> all outputs zero
    e.mask = 8'hFF; e.lw = 0; e.ctrl = 0;
    step();
    // 3: release reset, present plain ALU op; E still cleared
    v.rst_n = 1; clr_d();
    v.rw_m = 0; v.wr_m = 0; v.alu_m = 0; v.rw_w = 0; v.wr_w = 0; v.res_w = 0;
    v.valid_d = 1; v.rs = 1; v.rd1 = 5; v.rt = 2; v.rd2 = 7; v.rd = 3; v.regwrite = 1; v.aluc = 3'b010;
    e.mask = M_CT | M_LW | M_CN | M_A;
    step();
    // 4: plain load visible; set up forwarding sources (don't match rs=1/rt=2)
    v.rs = 3; v.rd1 = 32'h11; v.rt = 5; v.rd2 = 32'h22; v.aluc = 3'b110;
    v.rw_m = 1; v.wr_m = 3; v.alu_m = 32'hAA; v.rw_w = 1; v.wr_w = 3; v.res_w = 32'hBB;
    e.mask = 8'hFF; e.srca = 5; e.srcb = 7; e.wdata = 7; e.wreg = 2; e.aluc = 3'b010; e.ctrl = 4'b1100;
    step();
    // 5: rs_e=3 matches MEM and WB -> MEM wins
    e.mask = M_A | M_B | M_WR | M_AC; e.srca = 32'hAA; e.srcb = 32'h22; e.wreg = 5; e.aluc = 3'b110;
    step();
    // 6: same instruction recaptured, MEM write disabled -> WB
    v.rw_m = 0;
    v.rs = 0; v.rd1 = 32'h33; v.rt = 3; v.rd2 = 32'h44; v.aluc = 3'b010;
    e.mask = M_A | M_B; e.srca = 32'hBB; e.srcb = 32'h22;
    step();
    // 7: rs_e=0 with writereg_m=0 -> no forwarding; rt_e=3 forwards from WB
    v.rw_m = 1; v.wr_m = 0; v.alu_m = 32'hAA; v.rw_w = 1; v.wr_w = 3; v.res_w = 32'hBB;
    clr_d(); v.valid_d = 1; v.memtoreg = 1; v.regwrite = 1; v.alusrc = 1; v.rt = 4;
    v.imm = 8; v.rd1 = 32'h100; v.aluc = 3'b010;
    e.mask = M_A | M_WD | M_B; e.srca = 32'h33; e.wdata = 32'hBB; e.srcb = 32'hBB;
    step();
    // 8: load in E, dependent in D -> lwstall
    v.rw_m = 0; v.rw_w = 0;
    clr_d(); v.valid_d = 1; v.rs = 4; v.rt = 6; v.rd1 = 32'h55; v.rd2 = 32'h66;
    v.regwrite = 1; v.regdst = 1; v.rd = 7; v.aluc = 3'b010;
    e.mask = 8'hFF; e.lw = 1; e.ctrl = 4'b1110; e.srca = 32'h100; e.srcb = 8; e.wdata = 0;
    e.wreg = 4; e.aluc = 3'b010;
    step();
    // 9: bubble in E, hazard gone, decode held
    v.rw_m = 1; v.wr_m = 4; v.alu_m = 32'h77;
    e.mask = M_CT | M_LW | M_CN; e.ctrl = 0; e.lw = 0; e.bub = 1;
    step();
    // 10: dependent captured; rs_e=4 forwarded from WB
    v.rw_m = 0; v.rw_w = 1; v.wr_w = 4; v.res_w = 32'h99;
    clr_d(); v.valid_d = 1; v.rs = 1; v.rt = 2; v.rd1 = 32'hA1; v.rd2 = 32'hB2;
    v.memwrite = 1; v.aluc = 3'b111;
    e.mask = 8'hFF; e.srca = 32'h99; e.srcb = 32'h66; e.wdata = 32'h66; e.wreg = 7;
    e.aluc = 3'b010; e.ctrl = 4'b1100; e.lw = 0; e.bub = 1;
    step();
    // 11: store in E; begin 3-cycle stall with new decode contents
    v.rw_w = 0; v.stall = 1;
    clr_d(); v.valid_d = 1; v.rs = 9; v.rt = 10; v.rd1 = 32'hDEAD; v.rd2 = 32'hBEEF;
    v.regwrite = 1; v.aluc = 3'b001;
    e.mask = 8'hFF; e.srca = 32'hA1; e.srcb = 32'hB2; e.wdata = 32'hB2; e.wreg = 2;
    e.aluc = 3'b111; e.ctrl = 4'b1001; e.bub = 1;
    step();
    // 12..14: held
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) v.flush = 1;
      e.mask = 8'hFF; e.srca = 32'hA1; e.srcb = 32'hB2; e.wdata = 32'hB2; e.wreg = 2;
      e.aluc = 3'b111; e.ctrl = 4'b1001; e.bub = 1; e.stl = 32'(i);
      step();
    end
    // 15: flush with stall -> bubble, datapath held
    v.stall = 0; v.flush = 0;
    clr_d(); v.valid_d = 1; v.alusrc = 1; v.imm = 32'hFFFF_FFFC; v.regdst = 1; v.rd = 9;
    v.rt = 2; v.rd2 = 32'h12; v.rs = 1; v.rd1 = 32'h10; v.aluc = 3'b010; v.regwrite = 1;
    e.mask = M_CT | M_AC | M_A | M_CN; e.ctrl = 0; e.aluc = 3'b111; e.srca = 32'hA1;
    e.bub = 2; e.stl = 3;
    step();
    // 16: immediate / regdst; rt_e=2 forwarded from MEM into writedata
    v.rw_m = 1; v.wr_m = 2; v.alu_m = 32'hCC;
    clr_d(); v.valid_d = 1; v.memtoreg = 1; v.regwrite = 1; v.alusrc = 1; v.rt = 4;
    v.imm = 4; v.rd1 = 32'h200; v.aluc = 3'b010;
    e.mask = 8'hFF; e.srca = 32'h10; e.srcb = 32'hFFFF_FFFC; e.wdata = 32'hCC; e.wreg = 9;
    e.aluc = 3'b010; e.ctrl = 4'b1100; e.bub = 2; e.stl = 3;
    step();
    // 17: load in E, dependent in D, stall asserted
    v.rw_m = 0;
    clr_d(); v.valid_d = 1; v.rs = 4; v.rt = 0; v.rd1 = 32'h45; v.rd2 = 32'h46;
    v.regwrite = 1; v.aluc = 3'b011; v.stall = 1;
    e.mask = M_CT | M_LW | M_WR | M_CN; e.ctrl = 4'b1110; e.lw = 1; e.wreg = 4;
    e.bub = 2; e.stl = 3;
    step();
    // 18: stall beats load-use; reset asserted during stall
    v.rst_n = 0;
    e.mask = M_CT | M_LW | M_CN; e.ctrl = 4'b1110; e.lw = 1; e.bub = 2; e.stl = 4;
    step();
    // 19: reset won; lwstall deasserted
    v.rst_n = 1; v.stall = 0;
    e.mask = 8'hFF; e.lw = 0;
    step();
    // 20: dependent captured normally
    e.mask = M_A | M_B | M_WR | M_AC | M_CT | M_LW | M_CN;
    e.srca = 32'h45; e.srcb = 32'h46; e.wreg = 0; e.aluc = 3'b011; e.ctrl = 4'b1100; e.lw = 0;
    step();

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline register for the 5-stage MIPS core.
- Captures decoded operands and control at the clock edge.
- Applies stall, flush and load-use bubble insertion.
- Resolves EX-stage RAW hazards by forwarding from MEM and WB.
- Outputs srca_e, srcb_e and alucontrol_e connect directly to the ALU's A, B and F inputs. writedata_e and writereg_e feed the EX/MEM register.

Parameters:
WIDTH, 32, datapath width
REGADDR, 5, register-specifier width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
stall_e  in  1  hold all E-stage registers
flush_e  in  1  load a bubble into E (e.g. branch mispredict)
valid_d  in  1  decode slot holds a real instruction
rd1_d, rd2_d  in  WIDTH  register-file read data
signimm_d  in  WIDTH  sign-extended immediate
rs_d, rt_d, rd_d  in  REGADDR  register specifiers
regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d  in  1  decoded control
alucontrol_d  in  3  ALU function code
regwrite_m  in  1  MEM-stage write enable
writereg_m  in  REGADDR  MEM-stage destination
aluout_m  in  WIDTH  MEM-stage ALU result
regwrite_w  in  1  WB-stage write enable
writereg_w  in  REGADDR  WB-stage destination
result_w  in  WIDTH  WB-stage result
lwstall  out  1  load-use hazard; decode/fetch must hold
srca_e, srcb_e  out  WIDTH  ALU operands
alucontrol_e  out  3  ALU function
writedata_e  out  WIDTH  forwarded store data
writereg_e  out  REGADDR  destination register
valid_e, regwrite_e, memtoreg_e, memwrite_e  out  1  registered control
bubble_cnt, stall_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Registered state: valid, rd1, rd2, signimm, rs, rt, rd, all control bits, alucontrol.
- Reset (reset_n=0 at posedge): all registers cleared to 0. Resulting outputs are all 0: srca_e, srcb_e, writedata_e, writereg_e, valid_e and all control outputs. Register 0 is never a forwarding source.
- Register update priority per posedge, highest first:
  1. reset.
  2. flush_e: bubble.
  3. stall_e: hold all registers.
  4. lwstall: bubble.
  5. Otherwise load all *_d inputs.
- Bubble definition: valid, regwrite, memwrite and memtoreg cleared. Datapath registers may load or hold, but outputs must not cause side effects.
- lwstall (combinational) = valid_e & memtoreg_e & (rt_e != 0) & (rs_d == rt_e | rt_d == rt_e) & valid_d & ~flush_e.
- Bubble insertion means a load-use hazard costs exactly one cycle; the next edge re-captures the held decode instruction.
- Forwarding for srca_e (combinational from the registered rs_e):
  - rs_e != 0, rs_e == writereg_m and regwrite_m: aluout_m.
  - else rs_e != 0, rs_e == writereg_w and regwrite_w: result_w.
  - else rd1_e.
  - MEM has priority over WB.
- writedata_e: the same forwarding rule applied to rt_e and rd2_e.
- srcb_e = alusrc_e ? signimm_e : writedata_e.
- writereg_e = regdst_e ? rd_e : rt_e.
- alucontrol_e passes straight from its register.
- Latency: one cycle from *_d to E outputs.
- Simultaneous cases:
  - flush_e with stall_e: flush wins.
  - reset mid-stall: reset wins, and lwstall deasserts the cycle after reset.

Optional Feature:
Macro ID_EX_STATS_EN.
- Defined:
  - bubble_cnt increments on each posedge where a bubble is inserted (flush_e or lwstall, not under reset/stall_e).
  - stall_cnt increments on each posedge with stall_e=1 and no reset/flush.
  - Both counters are 32-bit, wrap 0xFFFFFFFF -> 0, and reset to 0.
- Undefined: both outputs are tied to constant 0 and no counter flops exist.

Test Plan:
- Reset: assert reset_n=0 one edge with all *_d=1s -> every output 0, lwstall=0.
- Plain load: rs_d=1, rd1_d=5, rt_d=2, rd2_d=7, alusrc_d=0, alucontrol_d=3'b010 -> next cycle srca_e=5, srcb_e=7, alucontrol_e=3'b010.
- Forward priority: rs_e=3, writereg_m=3 with regwrite_m=1 and aluout_m=0xAA, writereg_w=3 with regwrite_w=1 and result_w=0xBB -> srca_e=0xAA. Drop regwrite_m -> srca_e=0xBB. Repeat with rs_e=0 -> rd1_e, no forwarding.
- Load-use: lw captured (memtoreg_e=1, rt_e=4), then rs_d=4 -> lwstall=1 and next edge valid_e=0, regwrite_e=0. Following edge captures the dependent instruction with lwstall=0.
- Stall/flush: stall_e=1 for 3 edges -> outputs unchanged, stall_cnt +3 if ID_EX_STATS_EN. flush_e=1 with stall_e=1 -> valid_e=0, bubble_cnt +1.
- Immediate/regdst: alusrc_d=1 with signimm_d=0xFFFFFFFC and regdst_d=1, rd_d=9 -> srcb_e=0xFFFFFFFC, writereg_e=9, writedata_e still the forwarded rt value.
